// File: rtl/uart_word_ctrl_if.sv
// uart_word_ctrl_if
// Groups the transmit handshake, UART transmitter, UART receiver and display
// signals of uart_word_ctrl.
//   slave  : the controller side (uart_word_ctrl itself)
//   master : the environment side (host logic, UART core, LED driver)
// Signals:
//   tx_word/tx_req/tx_ack/tx_done       word transmit handshake
//   Tx_DATA/Tx_WR/TX_BUSY               UART transmitter byte interface
//   Rx_DATA/Rx_VALID/Rx_FERROR/Rx_PERROR UART receiver byte interface
//   display_data/word_valid/rx_error/rx_timeout  LED driver side
interface uart_word_ctrl_if;
    logic [15:0] tx_word;
    logic        tx_req;
    logic        tx_ack;
    logic        tx_done;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        TX_BUSY;
    logic [7:0]  Rx_DATA;
    logic        Rx_VALID;
    logic        Rx_FERROR;
    logic        Rx_PERROR;
    logic [15:0] display_data;
    logic        word_valid;
    logic        rx_error;
    logic        rx_timeout;

    modport slave (
        input  tx_word, tx_req, TX_BUSY, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR,
        output tx_ack, tx_done, Tx_DATA, Tx_WR, display_data, word_valid, rx_error,
               rx_timeout
    );

    modport master (
        output tx_word, tx_req, TX_BUSY, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR,
        input  tx_ack, tx_done, Tx_DATA, Tx_WR, display_data, word_valid, rx_error,
               rx_timeout
    );
endinterface

// File: rtl/uart_word_ctrl.sv
// uart_word_ctrl
// Sequences 16-bit words to the UART transmitter as two bytes (high first) using
// a write/busy handshake, and reassembles received byte pairs into 16-bit display
// words with an inter-byte timeout and error substitution.
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   io_bus  uart_word_ctrl_if.slave (see interface for signal list)
// All outputs are registered. TX and RX paths are independent.
module uart_word_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [15:0] IDLE_PATTERN   = 16'hCCCC,
    parameter logic [15:0] ERR_PATTERN    = 16'hEEEE
) (
    input logic             clk,
    input logic             reset,
    uart_word_ctrl_if.slave io_bus
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {TIdle, TWr, TRise, TFall} tx_state_e;
    typedef enum logic       {RHi, RLo} rx_state_e;

    // ---------------- TX path ----------------
    tx_state_e   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_word,  w_tx_word_nxt;
    logic [7:0]  r_tx_data,  w_tx_data_nxt;
    logic        r_byte_lo,  w_byte_lo_nxt;
    logic        r_tx_ack,   w_tx_ack_nxt;
    logic        r_tx_wr,    w_tx_wr_nxt;
    logic        r_tx_done,  w_tx_done_nxt;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_word_nxt  = r_tx_word;
        w_tx_data_nxt  = r_tx_data;
        w_byte_lo_nxt  = r_byte_lo;
        w_tx_ack_nxt   = 1'b0;
        w_tx_wr_nxt    = 1'b0;
        w_tx_done_nxt  = 1'b0;
        unique case (r_tx_state)
            TIdle: begin
                if (io_bus.tx_req && !io_bus.TX_BUSY) begin
                    w_tx_word_nxt  = io_bus.tx_word;
                    w_tx_data_nxt  = io_bus.tx_word[15:8];
                    w_byte_lo_nxt  = 1'b0;
                    w_tx_ack_nxt   = 1'b1;
                    w_tx_state_nxt = TWr;
                end
            end
            TWr: begin
                // Strobe is registered, so it appears in the cycle after TWr.
                w_tx_wr_nxt    = 1'b1;
                w_tx_state_nxt = TRise;
            end
            TRise: begin
                if (io_bus.TX_BUSY) begin
                    w_tx_state_nxt = TFall;
                end
            end
            TFall: begin
                if (!io_bus.TX_BUSY) begin
                    if (!r_byte_lo) begin
                        w_tx_data_nxt  = r_tx_word[7:0];
                        w_byte_lo_nxt  = 1'b1;
                        w_tx_state_nxt = TWr;
                    end else begin
                        w_tx_done_nxt  = 1'b1;
                        w_tx_state_nxt = TIdle;
                    end
                end
            end
            default: w_tx_state_nxt = TIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TIdle;
            r_tx_word  <= 16'h0000;
            r_tx_data  <= 8'h00;
            r_byte_lo  <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_tx_wr    <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_word  <= w_tx_word_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_byte_lo  <= w_byte_lo_nxt;
            r_tx_ack   <= w_tx_ack_nxt;
            r_tx_wr    <= w_tx_wr_nxt;
            r_tx_done  <= w_tx_done_nxt;
        end
    end

    // ---------------- RX path ----------------
    rx_state_e       r_rx_state, w_rx_state_nxt;
    logic [7:0]      r_hi_byte,  w_hi_byte_nxt;
    logic [CntW-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [15:0]     r_disp,     w_disp_nxt;
    logic            r_word_vld, w_word_vld_nxt;
    logic            r_rx_err,   w_rx_err_nxt;
    logic            r_rx_tmo,   w_rx_tmo_nxt;
    logic            r_valid_d;
    logic            r_err_d;
    logic            w_err_lvl;
    logic            w_valid_evt;
    logic            w_err_evt;

    // Rising-edge detection so a level-held strobe counts only once.
    assign w_err_lvl   = io_bus.Rx_FERROR | io_bus.Rx_PERROR;
    assign w_valid_evt = io_bus.Rx_VALID & ~r_valid_d;
    assign w_err_evt   = w_err_lvl & ~r_err_d;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_hi_byte_nxt  = r_hi_byte;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_disp_nxt     = r_disp;
        w_word_vld_nxt = 1'b0;
        w_rx_err_nxt   = r_rx_err;
        w_rx_tmo_nxt   = 1'b0;
        if (w_err_evt) begin
            // Error wins over a coincident byte; any held high byte is dropped.
            w_disp_nxt     = ERR_PATTERN;
            w_rx_err_nxt   = 1'b1;
            w_hi_byte_nxt  = 8'h00;
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RHi;
        end else if (w_valid_evt) begin
            if (r_rx_state == RHi) begin
                w_hi_byte_nxt  = io_bus.Rx_DATA;
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = RLo;
            end else begin
                w_disp_nxt     = {r_hi_byte, io_bus.Rx_DATA};
                w_word_vld_nxt = 1'b1;
                w_rx_err_nxt   = 1'b0;
                w_rx_state_nxt = RHi;
            end
        end else if (r_rx_state == RLo) begin
            if (r_rx_cnt == CntLast) begin
                w_rx_tmo_nxt   = 1'b1;
                w_hi_byte_nxt  = 8'h00;
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = RHi;
            end else begin
                w_rx_cnt_nxt = r_rx_cnt + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RHi;
            r_hi_byte  <= 8'h00;
            r_rx_cnt   <= '0;
            r_disp     <= IDLE_PATTERN;
            r_word_vld <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_tmo   <= 1'b0;
            r_valid_d  <= 1'b0;
            r_err_d    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_hi_byte  <= w_hi_byte_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_disp     <= w_disp_nxt;
            r_word_vld <= w_word_vld_nxt;
            r_rx_err   <= w_rx_err_nxt;
            r_rx_tmo   <= w_rx_tmo_nxt;
            r_valid_d  <= io_bus.Rx_VALID;
            r_err_d    <= w_err_lvl;
        end
    end

    // ---------------- Outputs ----------------
    assign io_bus.tx_ack       = r_tx_ack;
    assign io_bus.tx_done      = r_tx_done;
    assign io_bus.Tx_DATA      = r_tx_data;
    assign io_bus.Tx_WR        = r_tx_wr;
    assign io_bus.display_data = r_disp;
    assign io_bus.word_valid   = r_word_vld;
    assign io_bus.rx_error     = r_rx_err;
    assign io_bus.rx_timeout   = r_rx_tmo;

endmodule

// File: tb/tb_uart_word_ctrl.sv
// tb_uart_word_ctrl
// Directed bench for uart_word_ctrl with a small UART transmitter model and
// scoreboard queues for transmitted bytes and reassembled words.
module tb_uart_word_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_word_ctrl_if bus();

    uart_word_ctrl #(
        .TIMEOUT_CYCLES(16),
        .IDLE_PATTERN  (16'hCCCC),
        .ERR_PATTERN   (16'hEEEE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_words[$];

    int tx_wr_cnt   = 0;
    int tx_ack_cnt  = 0;
    int tx_done_cnt = 0;
    int wv_cnt      = 0;
    int tmo_cnt     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: busy rises 2 cycles after a write, stays 20 cycles.
    logic model_en  = 1'b1;
    int   busy_dly  = 0;
    int   busy_left = 0;

    always @(negedge clk) begin
        if (model_en) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.TX_BUSY = 1'b0;
            end else if (busy_dly > 0) begin
                busy_dly--;
                if (busy_dly == 0) begin
                    bus.TX_BUSY = 1'b1;
                    busy_left   = 20;
                end
            end else if (bus.Tx_WR) begin
                busy_dly = 2;
            end
        end
    end

    // Output monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.Tx_WR) begin
                tx_wr_cnt++;
                chk("tx_byte_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) chk("tx_byte", 32'(bus.Tx_DATA), 32'(exp_tx.pop_front()));
            end
            if (bus.tx_ack)  tx_ack_cnt++;
            if (bus.tx_done) tx_done_cnt++;
            if (bus.rx_timeout) tmo_cnt++;
            if (bus.word_valid) begin
                wv_cnt++;
                chk("word_expected", 32'(exp_words.size() != 0), 32'd1);
                if (exp_words.size() != 0)
                    chk("word_value", 32'(bus.display_data), 32'(exp_words.pop_front()));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.Rx_DATA  = b;
        bus.Rx_VALID = 1'b1;
        step(3);
        bus.Rx_VALID = 1'b0;
        step(2);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && tx_done_cnt < target; i++) step();
        chk("tx_done_seen", 32'(tx_done_cnt), 32'(target));
    endtask

    int base_wr, base_done, base_wv;

    initial begin
        bus.tx_word   = 16'h0000;
        bus.tx_req    = 1'b0;
        bus.TX_BUSY   = 1'b0;
        bus.Rx_DATA   = 8'h00;
        bus.Rx_VALID  = 1'b0;
        bus.Rx_FERROR = 1'b0;
        bus.Rx_PERROR = 1'b0;
        step(3);
        reset = 1'b0;
        step(10);

        // Reset state
        chk("rst_display", 32'(bus.display_data), 32'h0000_CCCC);
        chk("rst_tx_wr",   32'(bus.Tx_WR),        32'd0);
        chk("rst_tx_ack",  32'(bus.tx_ack),       32'd0);
        chk("rst_tx_data", 32'(bus.Tx_DATA),      32'd0);
        chk("rst_wv",      32'(bus.word_valid),   32'd0);
        chk("rst_rx_err",  32'(bus.rx_error),     32'd0);
        chk("rst_pulses",  32'(tx_wr_cnt + tx_done_cnt + wv_cnt + tmo_cnt), 32'd0);

        // Word transmit A55A
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h5A);
        bus.tx_word = 16'hA55A;
        bus.tx_req  = 1'b1;
        step();
        bus.tx_req  = 1'b0;
        chk("ack_timing",   32'(bus.tx_ack),  32'd1);
        chk("hi_data_time", 32'(bus.Tx_DATA), 32'h0000_00A5);
        step();
        chk("wr_timing",    32'(bus.Tx_WR),   32'd1);
        wait_done(1);
        chk("tx_wr_count",  32'(tx_wr_cnt),     32'd2);
        chk("tx_ack_count", 32'(tx_ack_cnt),    32'd1);
        chk("tx_q_drained", 32'(exp_tx.size()), 32'd0);
        step(3);
        chk("tx_done_once", 32'(tx_done_cnt),   32'd1);

        // Good pair 12 34
        exp_words.push_back(16'h1234);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("pair_display", 32'(bus.display_data), 32'h0000_1234);
        chk("pair_wv_once", 32'(wv_cnt),           32'd1);
        chk("pair_rx_err",  32'(bus.rx_error),     32'd0);

        // High byte then parity error
        send_byte(8'h12);
        bus.Rx_PERROR = 1'b1;
        step();
        bus.Rx_PERROR = 1'b0;
        chk("err_latency",  32'(bus.display_data), 32'h0000_EEEE);
        step();
        chk("err_display",  32'(bus.display_data), 32'h0000_EEEE);
        chk("err_flag",     32'(bus.rx_error),     32'd1);
        chk("err_no_wv",    32'(wv_cnt),           32'd1);
        exp_words.push_back(16'hBEEF);
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("beef_display", 32'(bus.display_data), 32'h0000_BEEF);
        chk("beef_err_clr", 32'(bus.rx_error),     32'd0);

        // Timeout after lone high byte
        bus.Rx_DATA  = 8'h99;
        bus.Rx_VALID = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            if (i == 2) bus.Rx_VALID = 1'b0;
            step();
        end
        chk("tmo_not_early", 32'(bus.rx_timeout),   32'd0);
        step();
        chk("tmo_pulse",     32'(bus.rx_timeout),   32'd1);
        chk("tmo_display",   32'(bus.display_data), 32'h0000_BEEF);
        step();
        chk("tmo_one_cycle", 32'(bus.rx_timeout),   32'd0);
        chk("tmo_count",     32'(tmo_cnt),          32'd1);
        exp_words.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("post_tmo_word", 32'(bus.display_data), 32'h0000_0102);
        chk("wv_total",      32'(wv_cnt),           32'd3);

        // Reset while waiting for the high byte's busy to fall
        model_en     = 1'b0;
        base_wr      = tx_wr_cnt;
        base_done    = tx_done_cnt;
        exp_tx.push_back(8'h13);
        bus.tx_word  = 16'h1357;
        bus.tx_req   = 1'b1;
        step();
        bus.tx_req   = 1'b0;
        step(2);
        bus.TX_BUSY  = 1'b1;
        step(3);
        reset        = 1'b1;
        bus.TX_BUSY  = 1'b0;
        step(2);
        reset        = 1'b0;
        step(10);
        chk("rst_mid_wr",   32'(tx_wr_cnt - base_wr),     32'd1);
        chk("rst_mid_done", 32'(tx_done_cnt - base_done), 32'd0);
        chk("rst_mid_data", 32'(bus.Tx_DATA),             32'd0);

        model_en    = 1'b1;
        base_wv     = tx_ack_cnt;
        exp_tx.push_back(8'h24);
        exp_tx.push_back(8'h68);
        bus.tx_word = 16'h2468;
        bus.tx_req  = 1'b1;
        step();
        bus.tx_req  = 1'b0;
        chk("post_rst_ack",  32'(bus.tx_ack),  32'd1);
        chk("post_rst_data", 32'(bus.Tx_DATA), 32'h0000_0024);
        wait_done(base_done + 1);
        chk("post_rst_wr",   32'(tx_wr_cnt - base_wr), 32'd3);
        chk("tx_q_final",    32'(exp_tx.size()),       32'd0);
        chk("word_q_final",  32'(exp_words.size()),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
